// File: rtl/seq_div_signed_if.sv
// Handshake and operand/result bundle for the iterative signed/unsigned divider.
interface seq_div_signed_if #(
  parameter int N = 8,
  parameter int M = N
);
  logic         start;
  logic         sgn;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         busy;
  logic         done;
  logic         div0;
  logic         ovf;

  modport master (
    output start, sgn, A, B,
    input  Q, R, busy, done, div0, ovf
  );

  modport slave (
    input  start, sgn, A, B,
    output Q, R, busy, done, div0, ovf
  );
endinterface

// File: rtl/seq_div_signed.sv
// Restoring divider, one quotient bit per cycle, on operand magnitudes with a final sign fix-up.
// Truncating division: remainder carries the dividend's sign.
module seq_div_signed #(
  parameter int N = 8,
  parameter int M = N
) (
  input  logic             clk,
  input  logic             rst,
  seq_div_signed_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  dq_reg;      // dividend magnitude shifting out, quotient bits shifting in
  logic [M-1:0]  p_reg;
  logic [M-1:0]  bmag_reg;
  logic [M-1:0]  alow_reg;
  logic          neg_q_reg, neg_r_reg, div0_op_reg, ovf_op_reg;
  logic [N-1:0]  q_reg;
  logic [M-1:0]  r_reg;
  logic          busy_reg, done_reg, div0_reg, ovf_reg;

  logic          a_neg, b_neg;
  logic [N-1:0]  a_mag;
  logic [M-1:0]  b_mag;
  logic [M:0]    p_shift;
  logic          sub_ok;
  logic [M-1:0]  p_next;
  logic [N-1:0]  q_fix;
  logic [M-1:0]  r_fix;

  always_comb begin
    a_neg   = bus.sgn & bus.A[N-1];
    b_neg   = bus.sgn & bus.B[M-1];
    a_mag   = a_neg ? (~bus.A + 1'b1) : bus.A;
    b_mag   = b_neg ? (~bus.B + 1'b1) : bus.B;
    p_shift = {p_reg, dq_reg[N-1]};
    sub_ok  = (p_shift >= {1'b0, bmag_reg});
    // After a successful subtract the result is below |B|, so the low M bits are exact.
    p_next  = sub_ok ? (p_shift[M-1:0] - bmag_reg) : p_shift[M-1:0];
    q_fix   = neg_q_reg ? (~dq_reg + 1'b1) : dq_reg;
    r_fix   = neg_r_reg ? (~p_reg + 1'b1) : p_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = ITER;
      ITER:    if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      dq_reg      <= '0;
      p_reg       <= '0;
      bmag_reg    <= '0;
      alow_reg    <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      div0_op_reg <= 1'b0;
      ovf_op_reg  <= 1'b0;
      q_reg       <= '0;
      r_reg       <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      div0_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cnt_reg     <= CNT_INIT;
            dq_reg      <= a_mag;
            p_reg       <= '0;
            bmag_reg    <= b_mag;
            alow_reg    <= bus.A[M-1:0];
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            div0_op_reg <= (bus.B == '0);
            ovf_op_reg  <= bus.sgn & (bus.A == {1'b1, {(N-1){1'b0}}}) & (&bus.B);
            busy_reg    <= 1'b1;
          end
        end
        ITER: begin
          p_reg   <= p_next;
          dq_reg  <= {dq_reg[N-2:0], sub_ok};
          cnt_reg <= cnt_reg - CW'(1);
        end
        FIX: begin
          // Divide-by-zero bypasses the sign fix-up and returns the raw dividend bits.
          q_reg    <= div0_op_reg ? '1 : q_fix;
          r_reg    <= div0_op_reg ? alow_reg : r_fix;
          div0_reg <= div0_op_reg;
          ovf_reg  <= ovf_op_reg;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.div0 = div0_reg;
  assign bus.ovf  = ovf_reg;
endmodule
